// File: rtl/regfile_write_scheduler_pkg.sv
// Purpose: shared register-file geometry and write-request types for the
//          register file, the decode stage and the writeback scheduler.
// Latency: n/a (types and constants only). Backpressure: n/a.
package regfile_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS   = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // Register 0 is hard-wired: writes to it are dropped, reservations ignored.
  localparam reg_addr_t ZERO_REG = 3'd0;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Purpose: bundle of the writeback requester bus, register-file write port,
//          reservation handshake and hazard queries of the write scheduler.
// Latency/backpressure: wiring only; req_ready/rsv_ready carry the backpressure.
// Ports: none (signals only). master = requesters/issue/decode side,
//        slave = regfile_write_scheduler.
interface regfile_write_scheduler_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*REG_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          rf_write_enable;
  logic [REG_ADDR_W-1:0]         rf_write_addr;
  logic [REG_DATA_W-1:0]         rf_write_data;

  logic                          rsv_valid;
  logic [REG_ADDR_W-1:0]         rsv_addr;
  logic                          rsv_ready;

  logic [REG_ADDR_W-1:0]         chk_addr1;
  logic [REG_ADDR_W-1:0]         chk_addr2;
  logic                          chk_busy1;
  logic                          chk_busy2;

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr, chk_addr1, chk_addr2,
    input  req_ready, rf_write_enable, rf_write_addr, rf_write_data,
           rsv_ready, chk_busy1, chk_busy2
  );

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr, chk_addr1, chk_addr2,
    output req_ready, rf_write_enable, rf_write_addr, rf_write_data,
           rsv_ready, chk_busy1, chk_busy2
  );

endinterface

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Purpose: combinational round-robin arbiter, one-hot grant plus next pointer.
// Latency: 0 cycles (pure combinational). Backpressure: grant only to valid bits.
// Ports: valid_i[N] requests, ptr_i search start; grant_o[N] one-hot grant,
//        next_ptr_o = (granted index + 1) mod N, or ptr_i when nothing granted.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  logic found;

  // Index base+off folded back into 0..N-1 (base is always < N).
  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    while (s >= N) s = s - N;
    return s;
  endfunction

  always_comb begin
    grant_o    = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && valid_i[wrap_idx(int'(ptr_i), k)]) begin
        grant_o[wrap_idx(int'(ptr_i), k)] = 1'b1;
        next_ptr_o = PTR_W'(wrap_idx(int'(ptr_i), k + 1));
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Purpose: round-robin share of the register-file write port plus per-register busy scoreboard.
// Latency: handshake at edge N -> rf_write_* valid in cycle after N, lands at edge N+1.
// Backpressure: req_ready is the one-hot grant; rsv_ready=0 while the target is busy.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the requester
//        bus, register-file write port, reservation handshake and hazard queries.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  regfile_write_scheduler_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    ptr_q, ptr_d, arb_next_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic                hs;
  wr_req_t             sel;
  wr_req_t             wr_q, wr_d;
  logic                wr_en_q, wr_en_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                rsv_take;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .valid_i    (bus.req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .next_ptr_o (arb_next_ptr)
  );

  assign bus.req_ready = grant;
  // The grant is only ever raised on a valid bit, so any grant is a handshake.
  assign hs = |grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.addr = bus.req_addr[REG_ADDR_W*i +: REG_ADDR_W];
        sel.data = bus.req_data[REG_DATA_W*i +: REG_DATA_W];
      end
    end
  end

  // Arbiter already returns ptr_i when nothing is granted.
  assign ptr_d = arb_next_ptr;

  // Writes to register 0 consume a slot but never pulse the write enable.
  assign wr_en_d = hs && (sel.addr != ZERO_REG);
  assign wr_d    = hs ? sel : wr_q;

  assign bus.rsv_ready = !busy_q[bus.rsv_addr];
  assign rsv_take      = bus.rsv_valid && bus.rsv_ready && (bus.rsv_addr != ZERO_REG);

  // Clear applied first so a reservation on the same edge wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_q.addr] = 1'b0;
    if (rsv_take) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rf_write_enable = wr_en_q;
  assign bus.rf_write_addr   = wr_q.addr;
  assign bus.rf_write_data   = wr_q.data;

  // No bypass: a reader seeing 0 here in the cycle after the write reads new data.
  assign bus.chk_busy1 = busy_q[bus.chk_addr1];
  assign bus.chk_busy2 = busy_q[bus.chk_addr2];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Purpose: directed bench for regfile_write_scheduler with a write scoreboard.
// Latency: expected writes are queued at issue and popped by the write monitor.
// Backpressure: grants and rsv_ready are compared against hand-computed values.
module tb_regfile_write_scheduler;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  wr_req_t exp_q[$];
  wr_req_t mon_e;

  regfile_write_scheduler_if #(.NUM_REQ(2)) bus ();

  regfile_write_scheduler #(.NUM_REQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] a, input logic [7:0] d);
    bus.req_addr[3*idx +: 3] = a;
    bus.req_data[8*idx +: 8] = d;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d);
    wr_req_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Write monitor: every enabled write slot must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rf_write_enable) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, required no write",
                 bus.rf_write_addr, bus.rf_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rf_write_addr !== mon_e.addr || bus.rf_write_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL write_data: got addr %0d data %0h, required addr %0d data %0h",
                   bus.rf_write_addr, bus.rf_write_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = 3'd0;
    bus.chk_addr1 = 3'd0;
    bus.chk_addr2 = 3'd0;

    // Reset state
    #2;
    chk("rst_grant", 32'(bus.req_ready), 32'h1);
    chk("rst_wen", 32'(bus.rf_write_enable), 32'h0);
    chk("rst_waddr", 32'(bus.rf_write_addr), 32'h0);
    chk("rst_wdata", 32'(bus.rf_write_data), 32'h0);
    chk("rst_rsv_ready", 32'(bus.rsv_ready), 32'h1);
    bus.chk_addr1 = 3'd5;
    bus.chk_addr2 = 3'd7;
    #1;
    chk("rst_busy1", 32'(bus.chk_busy1), 32'h0);
    chk("rst_busy2", 32'(bus.chk_busy2), 32'h0);
    bus.req_valid = 2'b00;
    #19 rst_n = 1'b1;
    tick();

    // Both requesters valid: grants alternate 0,1,0,1, write enable continuous
    set_req(0, 3'd3, 8'h11);
    set_req(1, 3'd5, 8'h22);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("alt_grant", 32'(bus.req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c > 0) chk("alt_wen", 32'(bus.rf_write_enable), 32'h1);
      if (c % 2 == 0) push(3'd3, 8'h11); else push(3'd5, 8'h22);
      tick();
    end
    bus.req_valid = 2'b00;
    #1;
    chk("alt_wen_last", 32'(bus.rf_write_enable), 32'h1);
    tick();
    #1;
    chk("alt_idle", 32'(bus.rf_write_enable), 32'h0);

    // Reserve reg4, second reserve blocked, req1 write clears it
    tick();
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 3'd4;
    bus.chk_addr1 = 3'd4;
    #1;
    chk("rsv4_ready", 32'(bus.rsv_ready), 32'h1);
    chk("rsv4_busy_pre", 32'(bus.chk_busy1), 32'h0);
    tick();
    #1;
    chk("rsv4_ready_again", 32'(bus.rsv_ready), 32'h0);
    chk("rsv4_busy", 32'(bus.chk_busy1), 32'h1);
    bus.rsv_valid = 1'b0;
    set_req(1, 3'd4, 8'hA5);
    bus.req_valid = 2'b10;
    #1;
    chk("w4_grant", 32'(bus.req_ready), 32'h2);
    push(3'd4, 8'hA5);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("w4_wen", 32'(bus.rf_write_enable), 32'h1);
    chk("w4_busy_inflight", 32'(bus.chk_busy1), 32'h1);
    tick();
    #1;
    chk("w4_busy_cleared", 32'(bus.chk_busy1), 32'h0);
    chk("w4_rsv_ready", 32'(bus.rsv_ready), 32'h1);

    // Register 0 write and reservation
    set_req(0, 3'd0, 8'hFF);
    bus.req_valid = 2'b01;
    #1;
    chk("r0_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("r0_wen", 32'(bus.rf_write_enable), 32'h0);
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 3'd0;
    bus.chk_addr1 = 3'd0;
    #1;
    chk("r0_rsv_ready", 32'(bus.rsv_ready), 32'h1);
    tick();
    bus.rsv_valid = 1'b0;
    #1;
    chk("r0_busy", 32'(bus.chk_busy1), 32'h0);
    chk("r0_rsv_ready_after", 32'(bus.rsv_ready), 32'h1);

    // Reg2: landing write with a blocked reservation in the same cycle
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 3'd2;
    tick();
    bus.rsv_valid = 1'b0;
    set_req(0, 3'd2, 8'h33);
    bus.req_valid = 2'b01;
    #1;
    chk("r2_grant", 32'(bus.req_ready), 32'h1);
    push(3'd2, 8'h33);
    tick();
    bus.req_valid = 2'b00;
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 3'd2;
    #1;
    chk("r2_rsv_blocked", 32'(bus.rsv_ready), 32'h0);
    tick();
    bus.rsv_valid = 1'b0;
    bus.chk_addr1 = 3'd2;
    #1;
    chk("r2_busy_cleared", 32'(bus.chk_busy1), 32'h0);

    // Reg6: reservation taken at the landing edge of an unreserved write, set wins
    set_req(1, 3'd6, 8'h66);
    bus.req_valid = 2'b10;
    #1;
    chk("r6_grant", 32'(bus.req_ready), 32'h2);
    push(3'd6, 8'h66);
    tick();
    bus.req_valid = 2'b00;
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 3'd6;
    #1;
    chk("r6_rsv_ready", 32'(bus.rsv_ready), 32'h1);
    tick();
    bus.rsv_valid = 1'b0;
    bus.chk_addr2 = 3'd6;
    #1;
    chk("r6_set_wins", 32'(bus.chk_busy2), 32'h1);

    // Async reset in the cycle after a handshake to reg7
    set_req(0, 3'd7, 8'h77);
    bus.req_valid = 2'b01;
    #1;
    chk("r7_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(bus.rf_write_enable), 32'h0);
    chk("mid_rst_waddr", 32'(bus.rf_write_addr), 32'h0);
    chk("mid_rst_busy6", 32'(bus.chk_busy2), 32'h0);
    bus.req_valid = 2'b11;
    #1;
    chk("mid_rst_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    set_req(0, 3'd1, 8'h01);
    set_req(1, 3'd2, 8'h02);
    bus.req_valid = 2'b11;
    #1;
    chk("post_rst_grant0", 32'(bus.req_ready), 32'h1);
    push(3'd1, 8'h01);
    tick();
    bus.req_valid = 2'b10;
    #1;
    chk("post_rst_grant1", 32'(bus.req_ready), 32'h2);
    push(3'd2, 8'h02);
    tick();
    bus.req_valid = 2'b00;
    tick();

    // Lone requester 1, four consecutive writes
    for (int i = 1; i <= 4; i++) begin
      set_req(1, 3'(i), 8'h40 + 8'(i));
      bus.req_valid = 2'b10;
      #1;
      chk("lone_grant", 32'(bus.req_ready), 32'h2);
      if (i > 1) chk("lone_wen", 32'(bus.rf_write_enable), 32'h1);
      push(3'(i), 8'h40 + 8'(i));
      tick();
    end
    set_req(0, 3'd5, 8'h55);
    bus.req_valid = 2'b11;
    #1;
    chk("lone_ptr_back0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
